// File: rtl/mp3_stream_feeder.sv
// mp3_stream_feeder -- byte FIFO draining into the MP3 data SPI shifter in DREQ-gated bursts.
// Revision: 1.0
`default_nettype none

module mp3_stream_feeder #(
   parameter int DEPTH_LOG2 = 4,
   parameter int BURST      = 32,
   parameter int SPI_LAT    = 2
) (
   input  logic                  cpu_clock,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  wr_stb,
   input  logic [7:0]            wr_data,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  overrun,
   input  logic                  md_dreq,
   input  logic                  spi_busy,
   output logic                  md_start,
   output logic [7:0]            md_din,
   output logic                  active
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;

   localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [7:0]            BURST_LD = 8'(BURST - 1);
   localparam logic [2:0]            LAT_LD   = 3'(SPI_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                state, next_state;
   logic                  dreq_meta, dreq_s;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [7:0]            burst_cnt, burst_nxt;
   logic [2:0]            lat_cnt, lat_nxt;
   logic                  push, pop;

   assign fifo_full  = (fifo_level == LVL_FULL);
   assign fifo_empty = (fifo_level == '0);
   assign active     = (state != IDLE);

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign pop  = (state == ISSUE) && !fifo_empty;
   assign push = wr_stb && !flush && (!fifo_full || pop);

   always_ff @(posedge cpu_clock or posedge rst) begin
      if (rst) begin
         dreq_meta <= 1'b0;
         dreq_s    <= 1'b0;
      end else begin
         dreq_meta <= md_dreq;
         dreq_s    <= dreq_meta;
      end
   end

   always_ff @(posedge cpu_clock) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge cpu_clock or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overrun    <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overrun    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            fifo_level <= fifo_level + LVL_ONE;
         else if (pop && !push)
            fifo_level <= fifo_level - LVL_ONE;
         if (wr_stb && fifo_full && !pop)
            overrun <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      burst_nxt  = burst_cnt;
      lat_nxt    = lat_cnt;
      case (state)
         IDLE: begin
            if (enable && dreq_s && !fifo_empty && !spi_busy) begin
               next_state = ISSUE;
               burst_nxt  = BURST_LD;
            end
         end
         ISSUE: begin
            next_state = WAIT;
            lat_nxt    = LAT_LD;
         end
         WAIT: begin
            // The shifter's busy flag is not meaningful until lat_cnt runs out.
            if (lat_cnt != 3'd0) begin
               lat_nxt = lat_cnt - 3'd1;
            end else if (!spi_busy) begin
               if (burst_cnt == 8'd0) begin
                  next_state = IDLE;
               end else if (enable && !fifo_empty) begin
                  next_state = ISSUE;
                  burst_nxt  = burst_cnt - 8'd1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      if (flush)
         next_state = IDLE;
   end

   always_ff @(posedge cpu_clock or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         burst_cnt <= 8'd0;
         lat_cnt   <= 3'd0;
         md_start  <= 1'b0;
         md_din    <= 8'h00;
      end else begin
         state     <= next_state;
         burst_cnt <= burst_nxt;
         lat_cnt   <= lat_nxt;
         md_start  <= (next_state == ISSUE);
         if (next_state == ISSUE)
            md_din <= mem[rd_ptr];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mp3_stream_feeder.sv
// tb_mp3_stream_feeder -- directed, table-driven self-checking bench for mp3_stream_feeder.
// Revision: 1.0
`default_nettype none

module tb_mp3_stream_feeder;

   logic       cpu_clock = 1'b0;
   logic       rst       = 1'b1;
   logic       enable    = 1'b0;
   logic       flush     = 1'b0;
   logic       wr_stb    = 1'b0;
   logic [7:0] wr_data   = 8'h00;
   logic       md_dreq   = 1'b0;
   logic       spi_busy  = 1'b0;
   logic       fifo_full, fifo_empty, overrun, md_start, active;
   logic [4:0] fifo_level;
   logic [7:0] md_din;

   mp3_stream_feeder dut (
      .cpu_clock  (cpu_clock),
      .rst        (rst),
      .enable     (enable),
      .flush      (flush),
      .wr_stb     (wr_stb),
      .wr_data    (wr_data),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_level (fifo_level),
      .overrun    (overrun),
      .md_dreq    (md_dreq),
      .spi_busy   (spi_busy),
      .md_start   (md_start),
      .md_din     (md_din),
      .active     (active)
   );

   always #5 cpu_clock = ~cpu_clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Shifter model and start scoreboard: each md_start pops the next expected byte.
   int         cyc = 0;
   int         start_count = 0;
   int         prev_start_cyc = 0;
   int         last_start_cyc = 0;
   int         busy_len = 0;
   int         busy_cnt = 0;
   logic [7:0] exp_q[$];

   always @(posedge cpu_clock) begin
      #1;
      cyc++;
      if (md_start) begin
         start_count++;
         prev_start_cyc = last_start_cyc;
         last_start_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_unexpected: md_din=0x%0h with no byte outstanding", md_din);
         end else begin
            chk("start_data", int'(md_din), int'(exp_q.pop_front()));
         end
         busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      spi_busy = (busy_cnt != 0);
   end

   task automatic step();
      @(posedge cpu_clock);
      #2;
   endtask

   task automatic wr(input logic [7:0] d);
      wr_stb  = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      step();
      wr_stb = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (active && t < 200) begin
         step();
         t++;
      end
      chk(name, int'(active), 0);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       fl;
      int         lvl;
      logic       full;
      logic       empty;
      logic       ovr;
   } vec_t;

   vec_t tbl[22];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t;
      int fed;
      int din_bad;

      for (int i = 0; i < 16; i++) begin
         tbl[i].wr    = 1'b1;
         tbl[i].data  = 8'(8'h80 + i);
         tbl[i].fl    = 1'b0;
         tbl[i].lvl   = i + 1;
         tbl[i].full  = (i == 15);
         tbl[i].empty = 1'b0;
         tbl[i].ovr   = 1'b0;
      end
      tbl[16] = '{1'b1, 8'hEE, 1'b0, 16, 1'b1, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 8'h00, 1'b1,  0, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 8'h77, 1'b1,  0, 1'b0, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 8'h55, 1'b0,  1, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 8'h00, 1'b0,  1, 1'b0, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 8'h00, 1'b1,  0, 1'b0, 1'b1, 1'b0};

      // Reset values
      repeat (3) step();
      chk("rst_level",    int'(fifo_level), 0);
      chk("rst_empty",    int'(fifo_empty), 1);
      chk("rst_full",     int'(fifo_full), 0);
      chk("rst_overrun",  int'(overrun), 0);
      chk("rst_md_start", int'(md_start), 0);
      chk("rst_md_din",   int'(md_din), 0);
      chk("rst_active",   int'(active), 0);
      rst = 1'b0;
      step();

      // FIFO fill / overrun / flush table with the stream disabled
      for (int i = 0; i < 22; i++) begin
         wr_stb  = tbl[i].wr;
         wr_data = tbl[i].data;
         flush   = tbl[i].fl;
         step();
         wr_stb = 1'b0;
         flush  = 1'b0;
         chk($sformatf("tbl%0d_level", i),   int'(fifo_level), tbl[i].lvl);
         chk($sformatf("tbl%0d_full", i),    int'(fifo_full),  int'(tbl[i].full));
         chk($sformatf("tbl%0d_empty", i),   int'(fifo_empty), int'(tbl[i].empty));
         chk($sformatf("tbl%0d_overrun", i), int'(overrun),    int'(tbl[i].ovr));
      end
      chk("tbl_no_start", start_count, 0);

      // Five bytes streamed with a busy shifter
      md_dreq  = 1'b1;
      enable   = 1'b1;
      busy_len = 8;
      repeat (3) step();
      base = start_count;
      for (int i = 0; i < 5; i++) wr(8'(8'h11 + i));
      t = 0;
      while (start_count < base + 5 && t < 200) begin
         step();
         t++;
      end
      chk("t1_starts", start_count - base, 5);
      wait_idle("t1_active");
      chk("t1_level", int'(fifo_level), 0);
      chk("t1_pending", exp_q.size(), 0);

      // Burst limit: DREQ dropped after the 3rd start, burst still runs to 32
      busy_len = 0;
      base = start_count;
      fed = 0;
      for (int c = 0; c < 220; c++) begin
         if (!fifo_full && fed < 60) begin
            wr_stb  = 1'b1;
            wr_data = 8'(8'h40 + fed);
            exp_q.push_back(wr_data);
            fed++;
         end else begin
            wr_stb = 1'b0;
         end
         if (start_count - base >= 3) md_dreq = 1'b0;
         step();
      end
      wr_stb = 1'b0;
      chk("t3_burst_starts", start_count - base, 32);
      chk("t3_idle", int'(active), 0);
      base = start_count;
      md_dreq = 1'b1;
      t = 0;
      while (start_count == base && t < 4) begin
         step();
         t++;
      end
      chk("t3_resume", start_count - base, 1);
      enable = 1'b0;
      wait_idle("t3_stop");
      do_flush();
      chk("t3_flush_level", int'(fifo_level), 0);

      // Full FIFO with a write landing on the ISSUE pop
      for (int i = 0; i < 16; i++) wr(8'(8'h90 + i));
      chk("t4_full_before", int'(fifo_full), 1);
      enable = 1'b1;
      step();
      chk("t4_issue", int'(md_start), 1);
      wr_stb  = 1'b1;
      wr_data = 8'hA5;
      exp_q.push_back(8'hA5);
      enable  = 1'b0;
      step();
      wr_stb = 1'b0;
      chk("t4_level", int'(fifo_level), 16);
      chk("t4_full", int'(fifo_full), 1);
      chk("t4_overrun", int'(overrun), 0);
      wait_idle("t4_stop");
      do_flush();

      // Asynchronous reset during WAIT with bytes queued
      for (int i = 0; i < 10; i++) wr(8'(8'hB0 + i));
      enable = 1'b1;
      base = start_count;
      t = 0;
      while (start_count == base && t < 10) begin
         step();
         t++;
      end
      chk("t5_first_start", start_count - base, 1);
      step();
      rst = 1'b1;
      #1;
      chk("t5_level",    int'(fifo_level), 0);
      chk("t5_empty",    int'(fifo_empty), 1);
      chk("t5_full",     int'(fifo_full), 0);
      chk("t5_overrun",  int'(overrun), 0);
      chk("t5_md_start", int'(md_start), 0);
      chk("t5_md_din",   int'(md_din), 0);
      chk("t5_active",   int'(active), 0);
      exp_q.delete();
      step();
      rst = 1'b0;
      base = start_count;
      repeat (20) step();
      chk("t5_no_start", start_count - base, 0);

      // Long busy: second start one cycle after spi_busy falls, md_din held
      busy_len = 50;
      base = start_count;
      wr(8'hC1);
      wr(8'hC2);
      t = 0;
      while (start_count == base && t < 20) begin
         step();
         t++;
      end
      chk("t6_first", start_count - base, 1);
      din_bad = 0;
      t = 0;
      while (start_count < base + 2 && t < 100) begin
         step();
         t++;
         if (start_count < base + 2 && md_din != 8'hC1) din_bad++;
      end
      chk("t6_second", start_count - base, 2);
      chk("t6_gap", last_start_cyc - prev_start_cyc, 51);
      chk("t6_din_stable", din_bad, 0);
      busy_len = 0;
      wait_idle("t6_idle");
      chk("t6_pending", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
